// File: rtl/systolic_skew_feeder.sv
// Operand feeder/sequencer for an N x N systolic_pe array: skews left operands per row, drives PE enable/clear.
// Optional SKEW_FEEDER_STALL_CNT_EN compiles a saturating counter of stalled STREAM cycles onto stall_cnt.
module systolic_skew_feeder #(
  parameter int N  = 4,
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [15:0]     k_len,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_kiri_vec,
  input  logic [N*DW-1:0] in_atas_vec,
  output logic [N*DW-1:0] kiri_out,
  output logic [N*DW-1:0] atas_out,
  output logic            sys_pe_en,
  output logic            pe_rst_n,
  output logic            busy,
  output logic            done,
  output logic [31:0]     stall_cnt
);

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, FLUSH, DONE} state_t;

  localparam logic [15:0] FLUSH_LAST = 16'(N - 2);

  state_t          state, state_nxt;
  logic [15:0]     k_lat;
  logic [15:0]     cnt;
  logic            start_acc;
  logic            accept;
  logic            flush_step;
  logic            step;
  logic [N*DW-1:0] inj_kiri;
  logic [N*DW-1:0] inj_atas;

  always_comb begin
    state_nxt  = state;
    start_acc  = 1'b0;
    accept     = 1'b0;
    flush_step = 1'b0;
    case (state)
      IDLE: if (start) begin
        start_acc = 1'b1;
        state_nxt = CLEAR;
      end
      CLEAR: state_nxt = (k_lat == 16'd0) ? DONE : STREAM;
      STREAM: if (in_valid && in_ready) begin
        accept = 1'b1;
        if (cnt == k_lat - 16'd1) state_nxt = (N == 1) ? DONE : FLUSH;
      end
      FLUSH: begin
        flush_step = 1'b1;
        if (cnt == FLUSH_LAST) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    step     = accept | flush_step;
    // flush steps inject zeros on every lane so padding adds nothing to PE sums
    inj_kiri = accept ? in_kiri_vec : '0;
    inj_atas = accept ? in_atas_vec : '0;
  end

  // Stage boundary: control registers; done/busy trail DONE by one cycle so done lands after the last enabled cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      k_lat     <= '0;
      cnt       <= '0;
      in_ready  <= 1'b0;
      sys_pe_en <= 1'b0;
      pe_rst_n  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      if (start_acc) k_lat <= k_len;
      if (state_nxt != state) cnt <= '0;
      else if (step)          cnt <= cnt + 16'd1;
      in_ready  <= (state_nxt == STREAM);
      sys_pe_en <= step;
      pe_rst_n  <= (state_nxt != CLEAR);
      busy      <= (state_nxt != IDLE) || (state == DONE);
      done      <= (state == DONE);
    end
  end

  // Stage boundary: top operands are undelayed; the array adds its own per-row delay
  always_ff @(posedge clk) begin
    if (!rst || state == CLEAR) atas_out <= '0;
    else if (step)              atas_out <= inj_atas;
  end

  // Stage boundary: lane i runs through i+1 registers so it lags lane 0 by i steps
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic signed [DW-1:0] sr [0:i];

    always_ff @(posedge clk) begin
      if (!rst || state == CLEAR) begin
        for (int k = 0; k <= i; k++) sr[k] <= '0;
      end else if (step) begin
        sr[0] <= inj_kiri[i*DW +: DW];
        for (int k = 1; k <= i; k++) sr[k] <= sr[k-1];
      end
    end

    assign kiri_out[i*DW +: DW] = sr[i];
  end

`ifdef SKEW_FEEDER_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst || start_acc) stall_cnt <= '0;
    else if (state == STREAM && in_ready && !in_valid && stall_cnt != 32'hFFFF_FFFF)
      stall_cnt <= stall_cnt + 32'd1;
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: drives tiles into an N=4 and an N=1 instance and
// checks handshake, skew, enable counts, done timing and the products of a modelled PE array.
module tb_systolic_skew_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] k_len;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_kiri_vec, in_atas_vec;
  logic [63:0] kiri_out, atas_out;
  logic        sys_pe_en, pe_rst_n, busy, done;
  logic [31:0] stall_cnt;

  logic        s1_start;
  logic [15:0] s1_k_len;
  logic        s1_in_valid, s1_in_ready;
  logic [15:0] s1_in_kiri, s1_in_atas, s1_kiri_out, s1_atas_out;
  logic        s1_sys_pe_en, s1_pe_rst_n, s1_busy, s1_done;
  logic [31:0] s1_stall_cnt;

  systolic_skew_feeder #(.N(4), .DW(16)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_kiri_vec(in_kiri_vec), .in_atas_vec(in_atas_vec),
    .kiri_out(kiri_out), .atas_out(atas_out),
    .sys_pe_en(sys_pe_en), .pe_rst_n(pe_rst_n), .busy(busy), .done(done),
    .stall_cnt(stall_cnt)
  );

  systolic_skew_feeder #(.N(1), .DW(16)) dut1 (
    .clk(clk), .rst(rst), .start(s1_start), .k_len(s1_k_len),
    .in_valid(s1_in_valid), .in_ready(s1_in_ready),
    .in_kiri_vec(s1_in_kiri), .in_atas_vec(s1_in_atas),
    .kiri_out(s1_kiri_out), .atas_out(s1_atas_out),
    .sys_pe_en(s1_sys_pe_en), .pe_rst_n(s1_pe_rst_n), .busy(s1_busy), .done(s1_done),
    .stall_cnt(s1_stall_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model of the 4x4 PE array: kiri broadcast along a row, atas passed down one row per enabled cycle
  longint               acc   [4][4];
  logic signed [15:0]   apipe [4][4];
  logic signed [15:0]   a_in;

  always @(negedge clk) begin
    if (!pe_rst_n) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          acc[i][j]   = 0;
          apipe[i][j] = '0;
        end
    end else if (sys_pe_en) begin
      for (int i = 3; i >= 0; i--)
        for (int j = 0; j < 4; j++) begin
          a_in = (i == 0) ? $signed(atas_out[j*16 +: 16]) : apipe[i-1][j];
          acc[i][j] = acc[i][j] + longint'($signed(kiri_out[i*16 +: 16])) * longint'(a_in);
          apipe[i][j] = a_in;
        end
    end
  end

  logic [15:0] b_tab [16] = '{
    16'h0400, 16'hFC00, 16'h0200, 16'h0001,
    16'h0123, 16'h8000, 16'h7FFF, 16'h0000,
    16'hFFFF, 16'h0A00, 16'hF600, 16'h0040,
    16'h1234, 16'hEDCC, 16'h0800, 16'hC000
  };

  logic [63:0] beat_kiri [16];
  logic [63:0] beat_atas [16];
  int en_cnt, clear_cyc, done_cyc, pe_lows;
  bit seen_done;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, {59'd0, in_ready, sys_pe_en, busy, done, pe_rst_n}, 64'd0);
    chk({tag, "_kiri"}, kiri_out, 64'd0);
    chk({tag, "_atas"}, atas_out, 64'd0);
    chk({tag, "_stall"}, {32'd0, stall_cnt}, 64'd0);
  endtask

  task automatic chk_identity(input string tag);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        chk($sformatf("%s_c%0d%0d", tag, i, j), acc[i][j],
            64'(longint'($signed(b_tab[i*4+j])) * 1024));
  endtask

  task automatic run_tile(input int k, input bit stall_alt, input bit skew_chk, input bit hold_start);
    int bi;
    bit tog, prev_stall;
    logic [63:0] ek, ea;
    en_cnt = 0; clear_cyc = -1; done_cyc = -1; pe_lows = 0; seen_done = 0;
    bi = 0; tog = 0; prev_stall = 0;
    start = 1'b1; k_len = 16'(k);
    tick;
    if (!hold_start) start = 1'b0;
    for (int cyc = 0; cyc < 200 && !seen_done; cyc++) begin
      if (!pe_rst_n) begin
        pe_lows++;
        clear_cyc = cyc;
      end
      if (prev_stall) chk("stall_pe_en", {63'd0, sys_pe_en}, 64'd0);
      if (sys_pe_en) begin
        if (skew_chk) begin
          ek = '0;
          for (int i = 0; i < 4; i++)
            if (en_cnt == i) ek[i*16 +: 16] = 16'(i + 1);
          ea = (en_cnt == 0) ? 64'h0004_0003_0002_0001 : 64'd0;
          chk($sformatf("skew_kiri_e%0d", en_cnt), kiri_out, ek);
          chk($sformatf("skew_atas_e%0d", en_cnt), atas_out, ea);
        end
        en_cnt++;
      end
      if (done) begin
        done_cyc = cyc;
        seen_done = 1'b1;
        start = 1'b0;
        chk("busy_at_done", {63'd0, busy}, 64'd1);
      end
      prev_stall = 1'b0;
      if (in_ready) begin
        if (stall_alt && tog) begin
          in_valid = 1'b0;
          prev_stall = 1'b1;
        end else begin
          in_valid = 1'b1;
          in_kiri_vec = beat_kiri[bi];
          in_atas_vec = beat_atas[bi];
          bi++;
        end
        tog = !tog;
      end else begin
        in_valid = 1'b0;
      end
      tick;
    end
    chk("done_seen", {63'd0, seen_done}, 64'd1);
    chk("busy_after_done", {63'd0, busy}, 64'd0);
    chk("pe_rst_pulses", 64'(pe_lows), 64'd1);
  endtask

  initial begin
    int bi, en1, b1;
    bit s1_seen;
    rst = 1'b0; start = 1'b0; k_len = '0; in_valid = 1'b0;
    in_kiri_vec = '0; in_atas_vec = '0;
    s1_start = 1'b0; s1_k_len = '0; s1_in_valid = 1'b0; s1_in_kiri = '0; s1_in_atas = '0;
    tick; tick; tick;
    chk_reset_outputs("reset");
    rst = 1'b1;
    tick;
    chk("pe_rst_n_release", {63'd0, pe_rst_n}, 64'd1);

    // Reset in the middle of a K=8 tile after three accepted beats
    for (int b = 0; b < 16; b++) begin
      beat_kiri[b] = 64'h1111_2222_3333_4444;
      beat_atas[b] = 64'h5555_6666_7777_8888;
    end
    start = 1'b1; k_len = 16'd8;
    tick;
    start = 1'b0;
    bi = 0;
    for (int c = 0; c < 20 && bi < 3; c++) begin
      in_valid = in_ready;
      in_kiri_vec = beat_kiri[bi];
      in_atas_vec = beat_atas[bi];
      if (in_ready) bi++;
      tick;
    end
    chk("midtile_beats", 64'(bi), 64'd3);
    chk("midtile_kiri_live", {63'd0, kiri_out != 64'd0}, 64'd1);
    in_valid = 1'b0;
    rst = 1'b0;
    tick;
    chk_reset_outputs("midtile_rst");
    rst = 1'b1;
    tick;

    // Identity left matrix times B, no stalls
    for (int b = 0; b < 4; b++) begin
      beat_kiri[b] = '0;
      beat_kiri[b][b*16 +: 16] = 16'h0400;
      for (int j = 0; j < 4; j++) beat_atas[b][j*16 +: 16] = b_tab[b*4+j];
    end
    run_tile(4, 1'b0, 1'b0, 1'b0);
    chk("ident_en_cnt", 64'(en_cnt), 64'd7);
    chk("ident_done_lat", 64'(done_cyc - clear_cyc), 64'd9);
    chk_identity("ident");

    // Same tile back-to-back with in_valid toggling
    run_tile(4, 1'b1, 1'b0, 1'b0);
    chk("stall_en_cnt", 64'(en_cnt), 64'd7);
    chk_identity("stall");
`ifdef SKEW_FEEDER_STALL_CNT_EN
    chk("stall_cnt", {32'd0, stall_cnt}, 64'd3);
`else
    chk("stall_cnt", {32'd0, stall_cnt}, 64'd0);
`endif

    // Skew check with start held high through the tile
    beat_kiri[0] = 64'h0004_0003_0002_0001;
    beat_atas[0] = 64'h0004_0003_0002_0001;
    run_tile(1, 1'b0, 1'b1, 1'b1);
    chk("skew_en_cnt", 64'(en_cnt), 64'd4);

    // K = 0: no enabled cycles at all
    run_tile(0, 1'b0, 1'b0, 1'b0);
    chk("k0_en_cnt", 64'(en_cnt), 64'd0);

    // N = 1, K = 3: lanes pass straight through, no flush
    s1_start = 1'b1; s1_k_len = 16'd3;
    tick;
    s1_start = 1'b0;
    en1 = 0; b1 = 0; s1_seen = 1'b0;
    for (int c = 0; c < 40 && !s1_seen; c++) begin
      if (s1_sys_pe_en) begin
        chk($sformatf("n1_kiri_e%0d", en1), {48'd0, s1_kiri_out}, 64'(16'h0100 + 16'(en1)));
        chk($sformatf("n1_atas_e%0d", en1), {48'd0, s1_atas_out}, 64'(16'h0200 + 16'(en1)));
        en1++;
      end
      if (s1_done) s1_seen = 1'b1;
      s1_in_valid = s1_in_ready;
      s1_in_kiri = 16'h0100 + 16'(b1);
      s1_in_atas = 16'h0200 + 16'(b1);
      if (s1_in_ready) b1++;
      tick;
    end
    s1_in_valid = 1'b0;
    chk("n1_done_seen", {63'd0, s1_seen}, 64'd1);
    chk("n1_en_cnt", 64'(en1), 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

- Upstream operand feeder and sequencer for the N×N array of `systolic_pe` cells.
- Accepts one operand beat per cycle over a valid/ready stream. Each beat holds one column of the left matrix (N values) and one row of the top matrix (N values).
- Delays left operand row i by i enabled cycles to match the array's downward `out_bawah` propagation, and drives the global PE enable.
- Clears the accumulators before each tile, flushes the wavefront after the last beat, and signals completion to the VAE layer controller.

## Interface
Parameters:
- `N`, 4: array dimension (rows = columns); N ≥ 1
- `DW`, 16: operand width, signed Q5.10

Ports:
- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-low
- `start` in 1: begin tile; sampled only in IDLE
- `k_len` in 16: beats per tile (inner dimension K), latched on accepted `start`
- `in_valid` in 1: operand beat valid
- `in_ready` out 1: feeder accepts beat
- `in_kiri_vec` in N*DW: left operands; lane i (bits [i*DW +: DW]) → array row i
- `in_atas_vec` in N*DW: top operands; lane j → array column j
- `kiri_out` out N*DW: to `in_kiri` of row i (broadcast along row)
- `atas_out` out N*DW: to `in_atas` of row-0 PE, column j
- `sys_pe_en` out 1: global PE enable
- `pe_rst_n` out 1: accumulator clear to array `rst` (active-low)
- `busy` out 1: not IDLE
- `done` out 1: one-cycle pulse; all PE results final
- `stall_cnt` out 32: stalled STREAM cycles (see Configuration)

## Operation
- FSM states: IDLE → CLEAR → STREAM → FLUSH → DONE → IDLE.
- IDLE
  - `start`=1 latches `k_len`, goes to CLEAR.
  - `start` in any other state is ignored.
- CLEAR
  - Exactly one cycle with `pe_rst_n`=0.
  - Skew registers zeroed.
  - Next state: STREAM; if latched K=0, go straight to DONE.
- STREAM
  - `in_ready`=1 while accepted-beat count < K.
  - Beat accepted on `in_valid && in_ready`.
  - Each accepted beat advances the skew pipeline one step.
  - Cycles with `in_valid`=0 are stalls: nothing advances, `sys_pe_en`=0 next cycle.
  - After the K-th accept, go to FLUSH; if N=1, go to DONE.
- FLUSH
  - `in_ready`=0.
  - N−1 steps, each injecting zeros into row-0 kiri lane and all atas lanes.
  - Cannot stall.
- DONE
  - `done`=1 for one cycle, then IDLE.
- Skew rule: per step, `kiri_out` lane i = lane i of the beat injected i steps earlier.
  - Lane 0 is undelayed.
  - Zeros are injected before the first beat (from CLEAR) and during FLUSH.
  - `atas_out` lanes are undelayed; the array adds the per-row delay.
- No arithmetic in the block; values pass bit-exact. Zero padding contributes exactly 0 to the PE sums.
- Reset is priority over everything, including mid-tile: state IDLE, skew registers 0, counters 0.

## Timing
- Reset values:
  - `in_ready`, `sys_pe_en`, `busy`, `done` = 0
  - `kiri_out`, `atas_out` = 0
  - `pe_rst_n` = 0
  - `stall_cnt` = 0
- `pe_rst_n` returns to 1 the first cycle after `rst` deasserts.
- All outputs are registered.
- `busy`=1 from the cycle after an accepted `start` through the DONE cycle inclusive.
- A step taken at edge t (beat accept or flush step) presents its values at cycle t+1 with `sys_pe_en`=1.
- Outputs hold their values when `sys_pe_en`=0.
- Enabled cycles per tile = K + N − 1.
- If the last enabled cycle is T, then `done`=1 in cycle T+1 and PE `result` is final in cycle T+1.
- Minimum start-to-done, no stalls: 1 (CLEAR) + K + (N−1) + 1 cycles.

## Configuration
- Macro: `SKEW_FEEDER_STALL_CNT_EN`.
- Defined:
  - `stall_cnt` increments on every STREAM cycle with `in_ready`=1 and `in_valid`=0.
  - It saturates at 2^32−1.
  - It clears on an accepted `start` and on reset.
- Undefined: counter logic is not compiled; `stall_cnt` is tied to 0.

## Test plan
- Reset mid-tile (N=4, K=8, assert `rst` after 3 beats):
  - Next cycle is IDLE with all outputs at reset values.
  - A new tile then completes correctly.
- Identity product (N=4, K=4, left = I, top = B of Q5.10 values, e.g. 1.0 = 0x0400, no stalls):
  - Array `result` equals B.
  - `done` appears exactly 9 cycles after the CLEAR cycle (K + N − 1 = 7 enabled cycles, done on the cycle after the last).
  - Exactly 7 `sys_pe_en` cycles.
- Skew check (N=4, K=1, lanes 0x0001..0x0004):
  - `kiri_out` lane i is nonzero only on the i-th enabled cycle (0-based).
  - `atas_out` lanes are nonzero only on enabled cycle 0.
- Stalls (N=4, K=4, `in_valid` toggling 1,0,1,0):
  - Results identical to the no-stall run.
  - `sys_pe_en` low on each stall step.
  - With the macro defined, `stall_cnt` = 3.
- Edge sizes:
  - K=0 gives the sequence CLEAR, DONE with no `sys_pe_en`.
  - N=1, K=3 gives 3 enabled cycles, no FLUSH, then `done`.
- `start` held high during a tile is ignored. Back-to-back tiles each pulse `pe_rst_n` low exactly once.
